// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I subset controller.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_ADD  = 3'd1,
        CLS_ADDI = 3'd2,
        CLS_LW   = 3'd3,
        CLS_SW   = 3'd4,
        CLS_JAL  = 3'd5
    } instr_class_t;

    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [6:0] F7_ADD  = 7'b0000000;

    localparam logic [1:0] WB_MDR = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;

    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

endpackage

// File: rtl/instr_classifier.sv
// Combinational decode of {opcode, funct3, funct7} into an instruction class.
module instr_classifier
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output instr_class_t cls,
    output logic         legal
);

    // Match the supported encodings; anything else is reported as illegal.
    always_comb begin
        cls   = CLS_NONE;
        legal = 1'b0;
        case (opcode)
            OP_OP: begin
                if ((funct3 == F3_ADD) && (funct7 == F7_ADD)) begin
                    cls   = CLS_ADD;
                    legal = 1'b1;
                end else begin
                    cls   = CLS_NONE;
                    legal = 1'b0;
                end
            end
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    cls   = CLS_ADDI;
                    legal = 1'b1;
                end else begin
                    cls   = CLS_NONE;
                    legal = 1'b0;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_WORD) begin
                    cls   = CLS_LW;
                    legal = 1'b1;
                end else begin
                    cls   = CLS_NONE;
                    legal = 1'b0;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_WORD) begin
                    cls   = CLS_SW;
                    legal = 1'b1;
                end else begin
                    cls   = CLS_NONE;
                    legal = 1'b0;
                end
            end
            OP_JAL: begin
                cls   = CLS_JAL;
                legal = 1'b1;
            end
            default: begin
                cls   = CLS_NONE;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the add/addi/lw/sw/jal datapath with a shared
// memory port, memory-timeout and illegal-instruction traps.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       instr_opcode,
    input  logic [2:0]       instr_funct3,
    input  logic [6:0]       instr_funct7,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       state_o,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);

    // Counter value on the last permitted wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_r;
    instr_class_t     cls_r;
    logic [7:0]       wait_r;
    logic             trap_r;
    logic [1:0]       cause_r;
    logic [CNT_W-1:0] count_r;

    instr_class_t dec_cls_s;
    logic         dec_legal_s;
    logic         timeout_s;

    logic       mem_req_s, mem_we_s, mem_addr_sel_s, ir_write_s, mdr_write_s;
    logic       pc_write_s, pc_src_s, reg_write_s, alu_src_a_s, alu_src_b_s;
    logic [1:0] wb_sel_s, alu_op_s;

    instr_classifier u_classifier (
        .opcode (instr_opcode),
        .funct3 (instr_funct3),
        .funct7 (instr_funct7),
        .cls    (dec_cls_s),
        .legal  (dec_legal_s)
    );

    // A late mem_ready on the final permitted cycle still completes the access.
    assign timeout_s = (wait_r == WAIT_LAST) && !mem_ready;

    // Sequencer state, latched class, wait counter and sticky trap record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
            cls_r   <= CLS_NONE;
            wait_r  <= 8'd0;
            trap_r  <= 1'b0;
            cause_r <= CAUSE_NONE;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_r <= ST_DECODE;
                    end else if (timeout_s) begin
                        state_r <= ST_TRAP;
                        trap_r  <= 1'b1;
                        cause_r <= CAUSE_MEM_TIMEOUT;
                    end else begin
                        wait_r <= wait_r + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (dec_legal_s) begin
                        cls_r   <= dec_cls_s;
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_TRAP;
                        trap_r  <= 1'b1;
                        cause_r <= CAUSE_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    if ((cls_r == CLS_LW) || (cls_r == CLS_SW)) begin
                        state_r <= ST_MEM;
                        wait_r  <= 8'd0;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (cls_r == CLS_SW) begin
                            state_r <= ST_FETCH;
                            wait_r  <= 8'd0;
                        end else begin
                            state_r <= ST_WB;
                        end
                    end else if (timeout_s) begin
                        state_r <= ST_TRAP;
                        trap_r  <= 1'b1;
                        cause_r <= CAUSE_MEM_TIMEOUT;
                    end else begin
                        wait_r <= wait_r + 8'd1;
                    end
                end
                ST_WB: begin
                    state_r <= ST_FETCH;
                    wait_r  <= 8'd0;
                end
                ST_TRAP: begin
                    state_r <= ST_TRAP;
                end
                default: begin
                    state_r <= ST_TRAP;
                    trap_r  <= 1'b1;
                    cause_r <= CAUSE_ILLEGAL;
                end
            endcase
        end
    end

    // Datapath controls decoded from state, latched class and mem_ready.
    always_comb begin
        mem_req_s      = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_sel_s = 1'b0;
        ir_write_s     = 1'b0;
        mdr_write_s    = 1'b0;
        pc_write_s     = 1'b0;
        pc_src_s       = 1'b0;
        reg_write_s    = 1'b0;
        wb_sel_s       = WB_MDR;
        alu_src_a_s    = 1'b0;
        alu_src_b_s    = 1'b0;
        alu_op_s       = ALU_ADD;
        case (state_r)
            ST_FETCH: begin
                mem_req_s  = 1'b1;
                ir_write_s = mem_ready;
            end
            ST_EXEC: begin
                case (cls_r)
                    CLS_ADD: begin
                        alu_src_a_s = 1'b0;
                        alu_src_b_s = 1'b0;
                    end
                    CLS_JAL: begin
                        alu_src_a_s = 1'b1;
                        alu_src_b_s = 1'b1;
                    end
                    default: begin
                        alu_src_a_s = 1'b0;
                        alu_src_b_s = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_s      = 1'b1;
                mem_addr_sel_s = 1'b1;
                mem_we_s       = (cls_r == CLS_SW);
                if (mem_ready) begin
                    if (cls_r == CLS_SW) begin
                        pc_write_s = 1'b1;
                    end else begin
                        mdr_write_s = 1'b1;
                    end
                end else begin
                    pc_write_s  = 1'b0;
                    mdr_write_s = 1'b0;
                end
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                pc_write_s  = 1'b1;
                case (cls_r)
                    CLS_JAL: begin
                        wb_sel_s = WB_PC4;
                        pc_src_s = 1'b1;
                    end
                    CLS_LW: begin
                        wb_sel_s = WB_MDR;
                    end
                    default: begin
                        wb_sel_s = WB_ALU;
                    end
                endcase
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Retired-instruction counter: one step per PC update, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (pc_write_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Reset holds every control quiet so nothing is written in that cycle.
    assign mem_req      = mem_req_s      & ~rst;
    assign mem_we       = mem_we_s       & ~rst;
    assign mem_addr_sel = mem_addr_sel_s & ~rst;
    assign ir_write     = ir_write_s     & ~rst;
    assign mdr_write    = mdr_write_s    & ~rst;
    assign pc_write     = pc_write_s     & ~rst;
    assign pc_src       = pc_src_s       & ~rst;
    assign reg_write    = reg_write_s    & ~rst;
    assign wb_sel       = wb_sel_s       & {2{~rst}};
    assign alu_src_a    = alu_src_a_s    & ~rst;
    assign alu_src_b    = alu_src_b_s    & ~rst;
    assign alu_op       = alu_op_s       & {2{~rst}};
    assign trap         = trap_r         & ~rst;
    assign trap_cause   = cause_r        & {2{~rst}};
    assign state_o      = state_r;
    assign instr_count  = count_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each scenario queues per-cycle
// stimulus and expected control vectors, then replays and compares them.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  instr_opcode;
    logic [2:0]  instr_funct3;
    logic [6:0]  instr_funct7;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, mdr_write;
    logic        pc_write, pc_src, reg_write, alu_src_a, alu_src_b, trap;
    logic [1:0]  wb_sel, alu_op, trap_cause;
    logic [2:0]  state_o;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;

    logic        rdy_q[$];
    logic        rst_q[$];
    logic [19:0] exp_q[$];

    // Expected-vector fields: {state[19:17], req, we, asel, irw, mdrw, pcw,
    // pcs, rw, wb_sel[8:7], src_a, src_b, alu_op[4:3], trap, cause[1:0]}
    localparam logic [19:0] S0 = 20'h00000, S1 = 20'h20000, S2 = 20'h40000;
    localparam logic [19:0] S3 = 20'h60000, S4 = 20'h80000, S5 = 20'hA0000;
    localparam logic [19:0] REQ  = 20'h10000, WE   = 20'h08000, ASEL = 20'h04000;
    localparam logic [19:0] IRW  = 20'h02000, MDRW = 20'h01000, PCW  = 20'h00800;
    localparam logic [19:0] PCS  = 20'h00400, RW   = 20'h00200, WB10 = 20'h00100;
    localparam logic [19:0] WB01 = 20'h00080, SA   = 20'h00040, SB   = 20'h00020;
    localparam logic [19:0] TRP  = 20'h00004, TC10 = 20'h00002, TC01 = 20'h00001;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_opcode (instr_opcode),
        .instr_funct3 (instr_funct3),
        .instr_funct7 (instr_funct7),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .mdr_write    (mdr_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .state_o      (state_o),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] obs();
        return {state_o, mem_req, mem_we, mem_addr_sel, ir_write, mdr_write,
                pc_write, pc_src, reg_write, wb_sel, alu_src_a, alu_src_b,
                alu_op, trap, trap_cause};
    endfunction

    task automatic sched(input logic r, input logic rs, input logic [19:0] e);
        rdy_q.push_back(r);
        rst_q.push_back(rs);
        exp_q.push_back(e);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        instr_opcode = op;
        instr_funct3 = f3;
        instr_funct7 = f7;
    endtask

    task automatic test_reset();
        logic [19:0] got, want;
        int cyc = 0;
        sched(1'b1, 1'b1, S0);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
        total++;
        if (instr_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d want=0", instr_count);
        end
    endtask

    task automatic test_add();
        logic [19:0] got, want;
        int cyc = 0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        sched(1'b1, 1'b0, S0 | REQ | IRW);
        sched(1'b1, 1'b0, S1);
        sched(1'b1, 1'b0, S2);
        sched(1'b1, 1'b0, S4 | RW | PCW | WB01);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL add cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
        total++;
        if (instr_count !== 32'd1 || state_o !== 3'd0) begin
            bad++;
            $display("FAIL add_retire got cnt=%0d st=%0d want cnt=1 st=0", instr_count, state_o);
        end
    endtask

    task automatic test_lw_wait();
        logic [19:0] got, want;
        int cyc = 0;
        set_instr(7'b0000011, 3'b010, 7'b1010101);
        sched(1'b1, 1'b0, S0 | REQ | IRW);
        sched(1'b1, 1'b0, S1);
        sched(1'b1, 1'b0, S2 | SB);
        sched(1'b0, 1'b0, S3 | REQ | ASEL);
        sched(1'b0, 1'b0, S3 | REQ | ASEL);
        sched(1'b0, 1'b0, S3 | REQ | ASEL);
        sched(1'b1, 1'b0, S3 | REQ | ASEL | MDRW);
        sched(1'b0, 1'b0, S4 | RW | PCW);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL lw cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
        total++;
        if (instr_count !== 32'd2 || state_o !== 3'd0) begin
            bad++;
            $display("FAIL lw_retire got cnt=%0d st=%0d want cnt=2 st=0", instr_count, state_o);
        end
    endtask

    task automatic test_sw();
        logic [19:0] got, want;
        int cyc = 0;
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        sched(1'b1, 1'b0, S0 | REQ | IRW);
        sched(1'b1, 1'b0, S1);
        sched(1'b1, 1'b0, S2 | SB);
        sched(1'b1, 1'b0, S3 | REQ | WE | ASEL | PCW);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sw cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
        total++;
        if (instr_count !== 32'd3 || state_o !== 3'd0) begin
            bad++;
            $display("FAIL sw_retire got cnt=%0d st=%0d want cnt=3 st=0", instr_count, state_o);
        end
    endtask

    task automatic test_jal();
        logic [19:0] got, want;
        int cyc = 0;
        set_instr(7'b1101111, 3'b111, 7'b1111111);
        sched(1'b1, 1'b0, S0 | REQ | IRW);
        sched(1'b1, 1'b0, S1);
        sched(1'b1, 1'b0, S2 | SA | SB);
        sched(1'b1, 1'b0, S4 | RW | PCW | PCS | WB10);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL jal cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] got, want;
        int cyc = 0;
        set_instr(7'b0010011, 3'b000, 7'b0100000);
        for (int i = 0; i < 2; i++) begin
            sched(1'b1, 1'b0, S0 | REQ | IRW);
            sched(1'b0, 1'b0, S1);
            sched(1'b0, 1'b0, S2 | SB);
            sched(1'b0, 1'b0, S4 | RW | PCW | WB01);
        end
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL addi_b2b cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
        total++;
        if (instr_count !== 32'd6) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=6", instr_count);
        end
    endtask

    task automatic test_illegal();
        logic [19:0] got, want;
        int cyc = 0;
        set_instr(7'h7F, 3'b000, 7'b0000000);
        sched(1'b1, 1'b0, S0 | REQ | IRW);
        sched(1'b1, 1'b0, S1);
        for (int i = 0; i < 20; i++) begin
            sched(i[0], 1'b0, S5 | TRP | TC01);
        end
        sched(1'b1, 1'b1, S5);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL illegal cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
        total++;
        if (instr_count !== 32'd0 || state_o !== 3'd0) begin
            bad++;
            $display("FAIL illegal_rst got cnt=%0d st=%0d want cnt=0 st=0", instr_count, state_o);
        end
    endtask

    task automatic test_timeout();
        logic [19:0] got, want;
        int cyc = 0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        for (int i = 0; i < 16; i++) begin
            sched(1'b0, 1'b0, S0 | REQ);
        end
        sched(1'b1, 1'b0, S5 | TRP | TC10);
        sched(1'b0, 1'b1, S5);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL timeout cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout_edge();
        logic [19:0] got, want;
        int cyc = 0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        for (int i = 0; i < 15; i++) begin
            sched(1'b0, 1'b0, S0 | REQ);
        end
        sched(1'b1, 1'b0, S0 | REQ | IRW);
        sched(1'b0, 1'b0, S1);
        sched(1'b0, 1'b0, S2);
        sched(1'b0, 1'b0, S4 | RW | PCW | WB01);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL timeout_edge cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
        total++;
        if (instr_count !== 32'd1) begin
            bad++;
            $display("FAIL edge_count got=%0d want=1", instr_count);
        end
    endtask

    task automatic test_rst_mid_sw();
        logic [19:0] got, want;
        int cyc = 0;
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        sched(1'b1, 1'b0, S0 | REQ | IRW);
        sched(1'b1, 1'b0, S1);
        sched(1'b1, 1'b0, S2 | SB);
        sched(1'b1, 1'b1, S3);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front(); rst = rst_q.pop_front(); want = exp_q.pop_front();
            @(negedge clk);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL rst_mid_sw cyc=%0d got=%h want=%h", cyc, got, want);
            end
            cyc++;
            @(posedge clk); #1;
        end
        total++;
        if (instr_count !== 32'd0 || state_o !== 3'd0) begin
            bad++;
            $display("FAIL rst_mid_sw_after got cnt=%0d st=%0d want cnt=0 st=0", instr_count, state_o);
        end
        rst = 1'b0;
    endtask

    // Bound on total run time in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_lw_wait();
        test_sw();
        test_jal();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_timeout_edge();
        test_rst_mid_sw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I subset datapath: add, addi, lw, sw, jal.
- Shares one unified instruction/data memory port between fetch and load/store.
- Drives every datapath enable and mux select from an FSM.
- Traps on illegal instructions and on memory that never returns ready.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready before a trap. Legal range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- instr_opcode  in  7  IR[6:0]
- instr_funct3  in  3  IR[14:12]
- instr_funct7  in  7  IR[31:25]
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (sw), 0 = read
- mem_addr_sel  out  1  0 = PC, 1 = alu_out register
- ir_write  out  1  load IR from memory read data
- mdr_write  out  1  load memory data register
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = alu_out register
- reg_write  out  1  register file write enable
- wb_sel  out  2  00 = MDR, 01 = alu_out, 10 = PC+4
- alu_src_a  out  1  0 = rs1 data, 1 = PC
- alu_src_b  out  1  0 = rs2 data, 1 = immediate
- alu_op  out  2  00 = add (only encoding used)
- state_o  out  3  current state, for debug
- trap  out  1  sticky trap flag
- trap_cause  out  2  01 = illegal, 10 = memory timeout
- instr_count  out  CNT_W  retired instructions

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset:
  - state = FETCH; trap, trap_cause, instr_count, wait counter and class register all 0.
  - While rst is high, every control output is forced to 0. No memory, register or PC write may occur in the reset cycle.
  - Reset mid-instruction abandons that instruction.
- Output timing: outputs are combinational in state, latched class and mem_ready. Unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_write=1 in the same cycle, then go to DECODE.
- DECODE:
  - Classify {opcode, funct3, funct7} into ADD, ADDI, LW, SW or JAL and latch the class.
  - ADD requires 0110011/000/0000000. ADDI requires 0010011/000. LW requires 0000011/010. SW requires 0100011/010. JAL requires 1101111.
  - Anything else: go to TRAP with cause 01. Otherwise go to EXEC.
- EXEC:
  - ALU result is captured by the datapath alu_out register every cycle.
  - ADD: src_a=0, src_b=0. ADDI, LW, SW: src_a=0, src_b=1. JAL: src_a=1, src_b=1.
  - Next state: LW and SW go to MEM; all other classes go to WB.
- MEM:
  - Outputs: mem_req=1, mem_addr_sel=1, mem_we=1 for SW only.
  - LW on ready: mdr_write=1, go to WB.
  - SW on ready: pc_write=1, pc_src=0, go to FETCH.
- WB:
  - Always reg_write=1 and pc_write=1, then go to FETCH.
  - ADD/ADDI: wb_sel=01, pc_src=0.
  - LW: wb_sel=00, pc_src=0.
  - JAL: wb_sel=10, pc_src=1.
- pc_write rule: asserted exactly once per instruction, in its final cycle. The PC stays stable throughout the instruction.
- Retire counter: instr_count increments on each pc_write and wraps modulo 2^CNT_W.
- Handshake:
  - While waiting, mem_req, mem_we and mem_addr_sel are held constant.
  - mem_ready is ignored when mem_req=0.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle without mem_ready.
  - When the counter reaches MEM_TIMEOUT, go to TRAP with cause 10. mem_ready arriving in that same cycle wins: no trap.
- TRAP: absorbing until rst. All enables 0, trap=1, trap_cause held.
- Zero-wait latency: add, addi, sw and jal take 4 cycles; lw takes 5.

Decomposition:
- Shared package ctrl_pkg:
  - state enum.
  - Opcode, funct3 and funct7 constants.
  - wb_sel, alu_op and trap_cause encodings.
  - Instruction class enum.
- Sub-module instr_classifier: combinational, {opcode, funct3, funct7} -> class plus legal flag. Used in DECODE.

Test Plan:
- add, mem_ready tied 1:
  - States go 0,1,2,4,0.
  - WB cycle shows reg_write=1, wb_sel=01, pc_write=1, pc_src=0.
  - instr_count goes 0 -> 1.
- lw with mem_ready held low 3 cycles in MEM:
  - mem_req=1 and mem_addr_sel=1 stable for 4 cycles.
  - mdr_write pulses once, WB shows wb_sel=00.
  - Total 8 cycles.
- sw, zero wait:
  - MEM cycle shows mem_we=1, pc_write=1, reg_write=0.
  - No WB state is visited; returns to FETCH after 4 cycles.
- jal:
  - EXEC shows src_a=1, src_b=1.
  - WB shows wb_sel=10, pc_src=1, reg_write=1.
- Illegal opcode 0x7F:
  - DECODE goes to TRAP; trap=1, trap_cause=01.
  - All enables stay 0 for 20 cycles.
  - rst then returns to FETCH with instr_count=0.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=16:
  - TRAP after 16 cycles, cause 10.
  - Repeat with mem_ready arriving on cycle 16: fetch completes, no trap.
- rst asserted in MEM of sw: mem_req and mem_we drop to 0 in that cycle; no write occurs.
